ascii_hex_parser: RTL and testbench

ASCII_HEX_PARSER -- requirements
Module: ascii_hex_parser

---
 rtl/ascii_pkg.sv | 24 ++
 rtl/ascii_to_nibble.sv | 37 +++
 rtl/ascii_hex_parser.sv | 96 +++++++++
 tb/tb_ascii_hex_parser.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/ascii_pkg.sv
// Shared ASCII constants, parser FSM state encoding and the nibble-to-ASCII
// mapping that the parser's classifier inverts.
package ascii_pkg;

  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam logic [7:0] ASCII_0    = 8'h30;
  localparam logic [7:0] ASCII_UC_A = 8'h41;
  localparam logic [7:0] ASCII_LC_A = 8'h61;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCUM   = 2'd1,
    ST_FULL    = 2'd2,
    ST_DISCARD = 2'd3
  } state_t;

  // Uppercase hex digit for a nibble; ascii_to_nibble is its exact inverse.
  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] n);
    if (n < 4'd10) nibble_to_ascii = ASCII_0 + {4'd0, n};
    else           nibble_to_ascii = ASCII_UC_A + {4'd0, n} - 8'd10;
  endfunction

endpackage

// File: rtl/ascii_to_nibble.sv
// Combinational byte classifier: hex digit -> nibble, CR/LF -> terminator.
// Lowercase 'a'-'f' are digits only when ASCII_HEX_LOWER_EN is defined.
module ascii_to_nibble
  import ascii_pkg::*;
(
  input  logic [7:0] ascii,
  output logic [3:0] nibble,
  output logic       is_digit,
  output logic       is_term
);

  logic [7:0] w_ofs;

  always_comb begin
    nibble   = 4'd0;
    is_digit = 1'b0;
    w_ofs    = 8'd0;
    is_term  = (ascii == ASCII_CR) || (ascii == ASCII_LF);
    if (ascii >= ASCII_0 && ascii <= ASCII_0 + 8'd9) begin
      w_ofs    = ascii - ASCII_0;
      nibble   = w_ofs[3:0];
      is_digit = 1'b1;
    end else if (ascii >= ASCII_UC_A && ascii <= ASCII_UC_A + 8'd5) begin
      w_ofs    = ascii - ASCII_UC_A + 8'd10;
      nibble   = w_ofs[3:0];
      is_digit = 1'b1;
    end
`ifdef ASCII_HEX_LOWER_EN
    else if (ascii >= ASCII_LC_A && ascii <= ASCII_LC_A + 8'd5) begin
      w_ofs    = ascii - ASCII_LC_A + 8'd10;
      nibble   = w_ofs[3:0];
      is_digit = 1'b1;
    end
`endif
  end

endmodule

// File: rtl/ascii_hex_parser.sv
// Parses CR/LF-terminated ASCII hex words of up to DIGITS digits.
// Optional macro ASCII_HEX_LOWER_EN accepts lowercase 'a'-'f' as digits.
module ascii_hex_parser
  import ascii_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic [4*DIGITS-1:0]   word_data,
  output logic                  word_valid,
  output logic                  err
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = $clog2(DIGITS + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DIGITS);

  logic [3:0]    w_nibble;
  logic          w_is_digit;
  logic          w_is_term;
  logic [CW-1:0] w_cnt_nxt;

  state_t        r_state;
  logic [W-1:0]  r_acc;
  logic [CW-1:0] r_cnt;

  ascii_to_nibble u_cls (
    .ascii    (rx_data),
    .nibble   (w_nibble),
    .is_digit (w_is_digit),
    .is_term  (w_is_term)
  );

  assign w_cnt_nxt = r_cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_acc      <= '0;
      r_cnt      <= '0;
      word_data  <= '0;
      word_valid <= 1'b0;
      err        <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      err        <= 1'b0;
      if (rx_valid) begin
        case (r_state)
          ST_IDLE: begin
            if (w_is_digit) begin
              r_acc   <= W'(w_nibble);
              r_cnt   <= CW'(1);
              r_state <= (DIGITS == 1) ? ST_FULL : ST_ACCUM;
            end else if (!w_is_term) begin
              err     <= 1'b1;
              r_state <= ST_DISCARD;
            end
          end
          ST_ACCUM: begin
            if (w_is_digit) begin
              r_acc   <= (r_acc << 4) | W'(w_nibble);
              r_cnt   <= w_cnt_nxt;
              if (w_cnt_nxt == CNT_MAX) r_state <= ST_FULL;
            end else if (w_is_term) begin
              word_data  <= r_acc;
              word_valid <= 1'b1;
              r_state    <= ST_IDLE;
            end else begin
              err     <= 1'b1;
              r_state <= ST_DISCARD;
            end
          end
          ST_FULL: begin
            // Any further digit is an overflow, handled like a bad byte.
            if (w_is_term) begin
              word_data  <= r_acc;
              word_valid <= 1'b1;
              r_state    <= ST_IDLE;
            end else begin
              err     <= 1'b1;
              r_state <= ST_DISCARD;
            end
          end
          ST_DISCARD: begin
            if (w_is_term) r_state <= ST_IDLE;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ascii_hex_parser.sv
// Table-driven directed vectors plus randomized bytes checked against a
// line-level reference model for ascii_hex_parser (DIGITS=4).
module tb_ascii_hex_parser;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [15:0] word_data;
  logic        word_valid;
  logic        err;

  int checks = 0;
  int errors = 0;

  ascii_hex_parser #(.DIGITS(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .word_data  (word_data),
    .word_valid (word_valid),
    .err        (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  ch;
    bit          vld;
    bit          rst;
    bit          ev;
    bit          ee;
    logic [15:0] ed;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic [7:0] ch, input bit ev, input bit ee,
                              input logic [15:0] ed);
    vec_t v;
    v.ch = ch; v.vld = 1'b1; v.rst = 1'b0; v.ev = ev; v.ee = ee; v.ed = ed;
    tbl.push_back(v);
  endfunction

  function automatic void add_rst();
    vec_t v;
    v.ch = 8'h00; v.vld = 1'b0; v.rst = 1'b1; v.ev = 1'b0; v.ee = 1'b0; v.ed = 16'h0;
    tbl.push_back(v);
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_out(input string tag, input bit ev, input bit ee, input logic [15:0] ed);
    check({tag, " word_valid"}, {15'd0, word_valid}, {15'd0, ev});
    check({tag, " err"},        {15'd0, err},        {15'd0, ee});
    check({tag, " word_data"},  word_data,           ed);
  endtask

  // Called at a negedge: present inputs for one cycle, return at next negedge.
  task automatic step(input logic [7:0] ch, input bit vld, input bit r);
    rx_data  = ch;
    rx_valid = vld;
    rst      = r;
    @(negedge clk);
    rx_valid = 1'b0;
    rst      = 1'b0;
  endtask

  // Reference model: tracks the current line as a digit count and value.
  int          m_len;
  bit          m_dead;
  logic [15:0] m_val;
  logic [15:0] m_word;

  function automatic int hexval(input logic [7:0] c);
    if (c >= "0" && c <= "9") return int'(c) - 48;
    if (c >= "A" && c <= "F") return int'(c) - 55;
`ifdef ASCII_HEX_LOWER_EN
    if (c >= "a" && c <= "f") return int'(c) - 87;
`endif
    return -1;
  endfunction

  function automatic void model_reset();
    m_len = 0; m_dead = 0; m_val = 0; m_word = 0;
  endfunction

  function automatic void model_byte(input logic [7:0] c, output bit ev, output bit ee);
    bit term;
    int d;
    term = (c == 8'h0D) || (c == 8'h0A);
    d    = hexval(c);
    ev = 0; ee = 0;
    if (m_dead) begin
      if (term) begin m_dead = 0; m_len = 0; end
    end else if (term) begin
      if (m_len > 0) begin ev = 1; m_word = m_val; end
      m_len = 0;
    end else if (d >= 0 && m_len < 4) begin
      m_val = (m_len == 0) ? 16'(d) : 16'(m_val * 16 + d);
      m_len++;
    end else begin
      ee = 1; m_dead = 1;
    end
  endfunction

  function automatic logic [7:0] rand_char();
    int k;
    string digs;
    digs = "0123456789ABCDEF";
    k = $urandom_range(0, 99);
    if (k < 65) return digs[$urandom_range(0, 15)];
    if (k < 80) return ($urandom_range(0, 1) != 0) ? 8'h0D : 8'h0A;
    if (k < 90) return 8'h61 + 8'($urandom_range(0, 5));
    return 8'($urandom_range(0, 255));
  endfunction

  function automatic void add_str(input string s, input logic [15:0] cur);
    for (int i = 0; i < s.len(); i++) add(s[i], 1'b0, 1'b0, cur);
  endfunction

  initial begin
    // "1A2F\r"
    add_str("1A2F", 16'h0000);  add(8'h0D, 1, 0, 16'h1A2F);
    // "7\n" then "BEEF\r\n"
    add("7", 0, 0, 16'h1A2F);   add(8'h0A, 1, 0, 16'h0007);
    add_str("BEEF", 16'h0007);  add(8'h0D, 1, 0, 16'hBEEF); add(8'h0A, 0, 0, 16'hBEEF);
    // "12G4\r" then "00FF\r"
    add_str("12", 16'hBEEF);    add("G", 0, 1, 16'hBEEF);
    add("4", 0, 0, 16'hBEEF);   add(8'h0D, 0, 0, 16'hBEEF);
    add_str("00FF", 16'hBEEF);  add(8'h0D, 1, 0, 16'h00FF);
    // "12345\r" then "ABCD\r"
    add_str("1234", 16'h00FF);  add("5", 0, 1, 16'h00FF); add(8'h0D, 0, 0, 16'h00FF);
    add_str("ABCD", 16'h00FF);  add(8'h0D, 1, 0, 16'hABCD);
    // lone terminator and invalid byte from IDLE
    add(8'h0D, 0, 0, 16'hABCD); add("Z", 0, 1, 16'hABCD); add(8'h0A, 0, 0, 16'hABCD);
`ifdef ASCII_HEX_LOWER_EN
    add_str("1234", 16'hABCD);  add(8'h0D, 1, 0, 16'h1234);
    add_str("abcd", 16'h1234);  add(8'h0D, 1, 0, 16'hABCD);
`else
    add("a", 0, 1, 16'hABCD);   add_str("bcd", 16'hABCD); add(8'h0D, 0, 0, 16'hABCD);
`endif
    // "12", reset, "3\r"
    add_str("12", 16'hABCD);    add_rst();
    add("3", 0, 0, 16'h0000);   add(8'h0D, 1, 0, 16'h0003);

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_out("reset", 0, 0, 16'h0000);
    rst = 1'b0;
    @(negedge clk);

    foreach (tbl[i]) begin
      step(tbl[i].ch, tbl[i].vld, tbl[i].rst);
      check_out($sformatf("vec%0d", i), tbl[i].ev, tbl[i].ee, tbl[i].ed);
    end

    // Pulses last exactly one cycle; idle cycles leave the partial word intact.
    step(8'h00, 0, 0);
    check_out("pulse_clear", 0, 0, 16'h0003);
    step("5", 1, 0); step(8'h00, 0, 0); step(8'h00, 0, 0); step("6", 1, 0);
    step(8'h0D, 1, 0);
    check_out("gap_word", 1, 0, 16'h0056);

    // Reset wins over a simultaneous terminator strobe mid-word.
    step("9", 1, 0);
    step(8'h0D, 1, 1);
    check_out("rst_dom", 0, 0, 16'h0000);
    step(8'h0D, 1, 0);
    check_out("rst_dom_after", 0, 0, 16'h0000);

    // Randomized bytes against the reference model.
    step(8'h00, 0, 1);
    model_reset();
    for (int n = 0; n < 800; n++) begin
      bit ev, ee;
      logic [7:0] c;
      if ($urandom_range(0, 3) == 0) begin
        step(8'h00, 0, 0);
        check_out("rand_idle", 0, 0, m_word);
      end else begin
        c = rand_char();
        model_byte(c, ev, ee);
        step(c, 1, 0);
        check_out($sformatf("rand%0d_%h", n, c), ev, ee, m_word);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
